// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood window generator: two line buffers turn a raster pixel stream
// into a sliding window for the Gaussian filter, with border, frame and drop flags.
module matrix_3x3_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 512,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_SUM   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33,
    output logic                  matrix_clken,
    output logic                  matrix_border,
    output logic                  start,
    output logic                  frame_done,
    output logic                  pix_drop
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            flush_q, flush_d;

    logic            accept;
    logic            restart;
    logic [RW-1:0]   pos_row;
    logic [CW-1:0]   pos_col;
    logic            is_last;
    logic            border;

    logic [DATA_WIDTH-1:0] win_q [3][3];
    logic [DATA_WIDTH-1:0] lb_q  [FIFO_SUM][IMG_WIDTH];
    logic                  clken_q, border_q, start_q, done_q, drop_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        flush_d = 1'b0;
        accept  = 1'b0;
        restart = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pix_valid && frame_start) begin
                    accept  = 1'b1;
                    restart = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (pix_valid) begin
                    accept  = 1'b1;
                    restart = frame_start;
                end
            end
            S_FLUSH: begin
                // Two-cycle tail lets the filter pipeline drain before start falls.
                flush_d = ~flush_q;
                if (flush_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        pos_row = restart ? '0 : row_q;
        pos_col = restart ? '0 : col_q;
        is_last = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
        border  = ({1'b0, pos_row} < (RW + 1)'(2)) || ({1'b0, pos_col} < (CW + 1)'(2));

        if (accept) begin
            if (is_last) begin
                row_d   = '0;
                col_d   = '0;
                state_d = S_FLUSH;
            end else begin
                state_d = S_ACTIVE;
                if (pos_col == COL_LAST) begin
                    col_d = '0;
                    row_d = pos_row + 1'b1;
                end else begin
                    col_d = pos_col + 1'b1;
                    row_d = pos_row;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            flush_q  <= 1'b0;
            clken_q  <= 1'b0;
            border_q <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            flush_q  <= flush_d;
            clken_q  <= accept;
            done_q   <= accept && is_last;
            drop_q   <= pix_valid && !accept;
            start_q  <= accept || (state_q != S_IDLE);
            if (accept) begin
                border_q <= border;
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb_q[1][pos_col];
                win_q[1][2] <= lb_q[0][pos_col];
                win_q[2][2] <= pix_data;
            end
        end
    end

    // NOTE: line buffers are deliberately not reset; stale contents are masked by matrix_border.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[1][pos_col] <= lb_q[0][pos_col];
            lb_q[0][pos_col] <= pix_data;
        end
    end

    assign matrix_p11    = win_q[0][0];
    assign matrix_p12    = win_q[0][1];
    assign matrix_p13    = win_q[0][2];
    assign matrix_p21    = win_q[1][0];
    assign matrix_p22    = win_q[1][1];
    assign matrix_p23    = win_q[1][2];
    assign matrix_p31    = win_q[2][0];
    assign matrix_p32    = win_q[2][1];
    assign matrix_p33    = win_q[2][2];
    assign matrix_clken  = clken_q;
    assign matrix_border = border_q;
    assign start         = start_q;
    assign frame_done    = done_q;
    assign pix_drop      = drop_q;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen on a 4x3 image: windows, borders, flags,
// gapped input, idle drops, mid-frame restart, flush drops and mid-frame reset.
module tb_matrix_3x3_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic          clken, border, start, done, drop;

    int n_tests = 0;
    int n_fail  = 0;
    int n_nb    = 0;
    int n_done  = 0;
    int n_start = 0;

    always #5 clk = ~clk;

    matrix_3x3_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_WIDTH(DW),
        .FIFO_SUM  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .matrix_p11   (p11),
        .matrix_p12   (p12),
        .matrix_p13   (p13),
        .matrix_p21   (p21),
        .matrix_p22   (p22),
        .matrix_p23   (p23),
        .matrix_p31   (p31),
        .matrix_p32   (p32),
        .matrix_p33   (p33),
        .matrix_clken (clken),
        .matrix_border(border),
        .start        (start),
        .frame_done   (done),
        .pix_drop     (drop)
    );

    function automatic logic [143:0] win();
        return {p11, p12, p13, p21, p22, p23, p31, p32, p33};
    endfunction

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present inputs for one clock edge, then sample outputs 1 time unit after it.
    task automatic step(input logic v, input logic fs, input logic [DW-1:0] d);
        pix_valid   = v;
        frame_start = fs;
        pix_data    = d;
        @(posedge clk);
        #1;
        if (start) n_start++;
    endtask

    task automatic send_pix(input int n, input int gap);
        logic [143:0] snap;
        int r;
        int c;
        for (int i = 0; i < n; i++) begin
            r = i / W;
            c = i % W;
            step(1'b1, i == 0, DW'(r * 16 + c));
            check("clken", clken, 1'b1);
            check("border", border, (r < 2) || (c < 2));
            check("frame_done", done, i == W * H - 1);
            check("p33", p33, DW'(r * 16 + c));
            check("start", start, 1'b1);
            check("drop", drop, 1'b0);
            if (!border) n_nb++;
            if (done) n_done++;
            if (r == 2 && c == 2)
                check("win_2_2", win(), {16'd0, 16'd1, 16'd2, 16'd16, 16'd17, 16'd18,
                                         16'd32, 16'd33, 16'd34});
            if (r == 2 && c == 3)
                check("win_2_3", win(), {16'd1, 16'd2, 16'd3, 16'd17, 16'd18, 16'd19,
                                         16'd33, 16'd34, 16'd35});
            snap = win();
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'b0, '0);
                check("gap_clken", clken, 1'b0);
                check("gap_hold", win(), snap);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2);
        check("rst_win", win(), '0);
        check("rst_flags", {clken, border, start, done, drop}, 5'b0);
        rst_n = 1'b1;

        // 1: back-to-back frame, start high for 14 cycles
        n_start = 0; n_nb = 0; n_done = 0;
        send_pix(W * H, 0);
        step(1'b0, 1'b0, '0);
        check("s1_flush1_start", start, 1'b1);
        check("s1_flush1_clken", clken, 1'b0);
        step(1'b0, 1'b0, '0);
        check("s1_flush2_start", start, 1'b1);
        step(1'b0, 1'b0, '0);
        check("s1_start_fall", start, 1'b0);
        check("s1_start_cycles", n_start, 14);
        check("s1_nonborder", n_nb, 2);
        check("s1_done_count", n_done, 1);

        // 2: gapped frame, one valid in three cycles
        n_nb = 0; n_done = 0;
        send_pix(W * H, 2);
        idle(2);
        check("s2_nonborder", n_nb, 2);
        check("s2_done_count", n_done, 1);

        // 3: pixels without frame_start while idle are dropped
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, DW'(100 + i));
            check("s3_drop", drop, 1'b1);
            check("s3_clken", clken, 1'b0);
        end
        step(1'b0, 1'b0, '0);
        check("s3_drop_clear", drop, 1'b0);
        n_nb = 0; n_done = 0;
        send_pix(W * H, 0);
        idle(3);
        check("s3_nonborder", n_nb, 2);
        check("s3_done_count", n_done, 1);

        // 4: frame restart after 6 pixels
        n_nb = 0; n_done = 0;
        send_pix(6, 0);
        check("s4_no_done_early", n_done, 0);
        send_pix(W * H, 0);
        check("s4_done_count", n_done, 1);
        check("s4_nonborder", n_nb, 2);
        idle(3);

        // 5: pixel in first flush cycle dropped; next frame two cycles after frame_done
        send_pix(W * H, 0);
        step(1'b1, 1'b0, 16'd99);
        check("s5_flush_drop", drop, 1'b1);
        check("s5_flush_clken", clken, 1'b0);
        step(1'b0, 1'b0, '0);
        n_nb = 0; n_done = 0;
        send_pix(W * H, 0);
        check("s5_next_done", n_done, 1);
        idle(3);

        // 6: one-cycle reset mid-frame, then a full frame
        send_pix(5, 0);
        rst_n = 1'b0;
        step(1'b0, 1'b0, '0);
        check("s6_rst_win", win(), '0);
        check("s6_rst_flags", {clken, border, start, done, drop}, 5'b0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'd7);
        check("s6_idle_drop", drop, 1'b1);
        n_nb = 0; n_done = 0;
        send_pix(W * H, 0);
        idle(3);
        check("s6_nonborder", n_nb, 2);
        check("s6_done_count", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
